// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared types and default widths for the pulse sequencer.
//   state_t     - sequencer FSM states
//   DEF_*_W     - default widths for the address, length and overrun fields
package pulse_seq_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_OVR_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_TX,
        S_LAG,
        S_RXW,
        S_DONE   // TX path finished, concurrent RX window still open
    } state_t;

endpackage

// File: rtl/pulse_seq_ctr.sv
// pulse_seq_ctr: loadable down-counter with a zero flag.
//   clk, rstn  - clock, async active-low reset
//   load       - load load_val (wins over dec)
//   load_val   - value to load
//   dec        - decrement by one, stops at zero
//   zero       - counter currently reads zero
module pulse_seq_ctr
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_seq.sv
// pulse_seq: TX/RX pulse sequencer. A trigger runs PA lead, TX address sweep,
// PA lag and an RX window (after the lag, or concurrent with TX).
//   clk, rstn                 - fabric clock, async active-low reset
//   en                        - enable; low aborts a running pulse
//   trig                      - trigger request
//   rx_mode                   - 0: RX after lag, 1: RX starts with first TX sample
//   txsmps/rxsmps             - TX waveform / RX window lengths
//   pa_lead/pa_lag            - PA guard cycles around TX
//   tx_addr/tx_valid          - DAC playback address and qualifier
//   pa_en, rx_valid, rx_first - PA enable, RX window, first RX cycle
//   busy                      - pulse in progress
//   overrun/overrun_clr       - saturating rejected-trigger count and its clear
module pulse_seq
    import pulse_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int OVR_W  = DEF_OVR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              trig,
    input  logic              rx_mode,
    input  logic [ADDR_W-1:0] txsmps,
    input  logic [CNT_W-1:0]  rxsmps,
    input  logic [CNT_W-1:0]  pa_lead,
    input  logic [CNT_W-1:0]  pa_lag,
    output logic [ADDR_W-1:0] tx_addr,
    output logic              tx_valid,
    output logic              pa_en,
    output logic              rx_valid,
    output logic              rx_first,
    output logic              busy,
    output logic [OVR_W-1:0]  overrun,
    input  logic              overrun_clr
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] txs_q, tx_addr_nx, c_txs, tx_last;
    logic [CNT_W-1:0]  rxs_q, lag_q, c_rxs, c_lag;
    logic              mode_q, c_mode, idle, accept;
    logic              ll_load, ll_dec, ll_zero;
    logic              rx_load, rx_dec, rx_zero;
    logic [CNT_W-1:0]  ll_val, rx_val;
    logic              rx_run, rx_run_nx, rx_first_nx;
    logic              tx_start, tx_done, rx_cstart;

    assign idle   = (state == S_IDLE);
    assign accept = idle && en && trig;

    // In IDLE the decision for the accepting edge is taken from the live
    // inputs; once running, only the copies captured at acceptance are used.
    assign c_txs   = idle ? txsmps  : txs_q;
    assign c_rxs   = idle ? rxsmps  : rxs_q;
    assign c_lag   = idle ? pa_lag  : lag_q;
    assign c_mode  = idle ? rx_mode : mode_q;
    assign tx_last = c_txs - 1'b1;

    always_comb begin
        state_nx    = state;
        tx_addr_nx  = tx_addr;
        ll_load     = 1'b0;
        ll_val      = '0;
        ll_dec      = 1'b0;
        rx_load     = 1'b0;
        rx_val      = '0;
        rx_dec      = 1'b0;
        rx_run_nx   = rx_run;
        rx_first_nx = 1'b0;
        tx_start    = 1'b0;
        tx_done     = 1'b0;
        rx_cstart   = 1'b0;

        // Concurrent RX window runs alongside whatever the TX path is doing.
        if (rx_run) begin
            if (rx_zero) rx_run_nx = 1'b0;
            else         rx_dec    = 1'b1;
        end

        case (state)
            S_IDLE: if (accept) begin
                if (txsmps != '0) begin
                    if (pa_lead != '0) begin
                        state_nx = S_LEAD;
                        ll_load  = 1'b1;
                        ll_val   = pa_lead - 1'b1;
                    end else begin
                        tx_start = 1'b1;
                    end
                end else begin
                    // No waveform: the whole TX path, guards included, is skipped.
                    rx_cstart = c_mode;
                    tx_done   = 1'b1;
                end
            end
            S_LEAD: if (ll_zero) tx_start = 1'b1; else ll_dec = 1'b1;
            S_TX: begin
                if (tx_addr == tx_last) begin
                    if (c_lag != '0) begin
                        state_nx = S_LAG;
                        ll_load  = 1'b1;
                        ll_val   = c_lag - 1'b1;
                    end else begin
                        tx_done = 1'b1;
                    end
                end else begin
                    tx_addr_nx = tx_addr + 1'b1;
                end
            end
            S_LAG:  if (ll_zero) tx_done = 1'b1; else ll_dec = 1'b1;
            S_RXW:  if (rx_zero) state_nx = S_IDLE; else rx_dec = 1'b1;
            S_DONE: if (!rx_run_nx) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        if (tx_start) begin
            state_nx   = S_TX;
            tx_addr_nx = '0;
            rx_cstart  = c_mode;
        end

        if (rx_cstart && (c_rxs != '0)) begin
            rx_load     = 1'b1;
            rx_val      = c_rxs - 1'b1;
            rx_run_nx   = 1'b1;
            rx_first_nx = 1'b1;
        end

        if (tx_done) begin
            if (c_mode) begin
                state_nx = rx_run_nx ? S_DONE : S_IDLE;
            end else if (c_rxs != '0) begin
                state_nx    = S_RXW;
                rx_load     = 1'b1;
                rx_val      = c_rxs - 1'b1;
                rx_first_nx = 1'b1;
            end else begin
                state_nx = S_IDLE;
            end
        end

        // Abort: drop everything; the pulse is never resumed.
        if (!en && !idle) begin
            state_nx    = S_IDLE;
            tx_addr_nx  = '0;
            rx_run_nx   = 1'b0;
            rx_first_nx = 1'b0;
            ll_load     = 1'b0;
            ll_dec      = 1'b0;
            rx_load     = 1'b0;
            rx_dec      = 1'b0;
        end
    end

    pulse_seq_ctr #(.CNT_W(CNT_W)) u_ll_ctr (
        .clk(clk), .rstn(rstn), .load(ll_load), .load_val(ll_val),
        .dec(ll_dec), .zero(ll_zero)
    );

    pulse_seq_ctr #(.CNT_W(CNT_W)) u_rx_ctr (
        .clk(clk), .rstn(rstn), .load(rx_load), .load_val(rx_val),
        .dec(rx_dec), .zero(rx_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txs_q  <= '0;
            rxs_q  <= '0;
            lag_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            txs_q  <= txsmps;
            rxs_q  <= rxsmps;
            lag_q  <= pa_lag;
            mode_q <= rx_mode;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            tx_addr  <= '0;
            rx_run   <= 1'b0;
            tx_valid <= 1'b0;
            pa_en    <= 1'b0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            tx_addr  <= tx_addr_nx;
            rx_run   <= rx_run_nx;
            tx_valid <= (state_nx == S_TX);
            pa_en    <= (state_nx == S_LEAD) || (state_nx == S_TX) || (state_nx == S_LAG);
            rx_valid <= (state_nx == S_RXW) || rx_run_nx;
            rx_first <= rx_first_nx;
            busy     <= (state_nx != S_IDLE);
        end
    end

    // Only triggers that arrive while enabled and busy are counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overrun <= '0;
        else if (overrun_clr)
            overrun <= '0;
        else if (trig && en && !idle && (overrun != '1))
            overrun <= overrun + 1'b1;
    end

endmodule

// File: doc/pulse_seq.md
# pulse_seq

Parametrised transmit/receive pulse sequencer for the RFSoC radar datapath, running in the ADC/DAC fabric clock domain between the PS register block and the DAC playback memory / ADC capture path. On each accepted trigger it enables the PA for a lead interval, then steps the DAC sample address through a programmable-length waveform, then holds the PA for a lag interval. It also opens a receive window of programmable length, either after the lag or concurrent with transmit, and counts triggers lost while busy. It generalises the earlier single-mode tx controller with configurable widths, PA guard times, an RX window, a concurrent mode, abort and overrun accounting.

## Interface
- ADDR_W, 14: width of DAC playback address and txsmps.
- CNT_W, 16: width of rxsmps, pa_lead, pa_lag.
- OVR_W, 16: width of saturating overrun counter.
- clk  in  1  fabric clock; all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  sequencer enable; low aborts any pulse.
- trig  in  1  single-cycle trigger request.
- rx_mode  in  1  0 = RX window after PA lag; 1 = RX window starts with first TX sample.
- txsmps  in  ADDR_W  TX waveform length in samples.
- rxsmps  in  CNT_W  RX window length in samples.
- pa_lead  in  CNT_W  PA-on cycles before first TX sample.
- pa_lag  in  CNT_W  PA-on cycles after last TX sample.
- tx_addr  out  ADDR_W  DAC playback address.
- tx_valid  out  1  tx_addr is valid.
- pa_en  out  1  PA enable.
- rx_valid  out  1  RX capture window.
- rx_first  out  1  first cycle of RX window.
- busy  out  1  pulse in progress.
- overrun  out  OVR_W  triggers rejected while busy, saturating.
- overrun_clr  in  1  synchronous clear of overrun.

## Operation
- All outputs registered. On reset: state IDLE, every output 0, internal counters 0.
- States: IDLE, LEAD, TX, LAG, RXW, DONE.
- IDLE and en=1 and trig=1: the trigger is accepted. txsmps, rxsmps, pa_lead, pa_lag and rx_mode are latched; later input changes do not affect the running pulse.
  - Next state is LEAD if pa_lead>0.
  - Otherwise TX if txsmps>0.
  - Otherwise the RX path is taken.
- txsmps=0: LEAD, TX and LAG are skipped and pa_en never asserts, regardless of pa_lead/pa_lag.
- LEAD: pa_en=1 for pa_lead cycles, then TX.
- TX: pa_en=1, tx_valid=1, tx_addr = 0,1,…,txsmps-1, one per cycle. Then LAG if pa_lag>0, otherwise the end-of-TX step.
- LAG: pa_en=1 for pa_lag cycles.
- rx_mode=0: RXW follows the TX path. rx_valid=1 for rxsmps cycles, with rx_first on the first of them. rxsmps=0 skips RXW.
- rx_mode=1: an independent RX counter starts in the cycle of tx_addr=0 (or in the first post-trigger cycle if txsmps=0). The pulse ends only when both the TX path and the RX window have completed.
- After the last active cycle the state returns to IDLE. busy is high exactly while the state is not IDLE.
- trig=1 while busy: ignored; overrun increments, saturating at all-ones.
- overrun_clr has priority over a simultaneous increment.
- en=0 in any non-IDLE state: next cycle pa_en, tx_valid, rx_valid, rx_first and busy are 0 and tx_addr returns to 0; state goes to IDLE. A pulse is never resumed.
- trig while en=0: ignored, not counted.

## Timing
- Trigger sampled at edge 0. The first output change is visible after edge 1 (latency 1).
- rx_mode=0, all lengths nonzero:
  - pa_en high for cycles 1 … L+T+G, where L = pa_lead, T = txsmps, G = pa_lag.
  - tx_valid high for cycles L+1 … L+T.
  - rx_valid high for cycles L+T+G+1 … L+T+G+R, where R = rxsmps.
  - busy high for cycles 1 … L+T+G+R.
- rx_mode=1: rx_valid high for cycles L+1 … L+R. busy high through cycle max(L+T+G, L+R).
- A new trigger is accepted in the first cycle busy reads 0. The minimum trigger period is therefore the busy length + 1.
- tx_addr holds its last value while tx_valid is low, except that it returns to 0 on abort.

## Structure
- pulse_seq_pkg: state enum and default widths ADDR_W/CNT_W/OVR_W.
- One sub-module, pulse_seq_ctr: a loadable CNT_W down-counter with a zero flag. It is instanced for the lead/lag counter and for the RX counter.
- The TX address counter is inline.

## Test plan
- rstn low mid-pulse, released: all outputs 0 and overrun 0 immediately on assertion; the next trigger behaves normally.
- L=2, T=4, G=3, R=5, rx_mode=0, trig at cycle 0:
  - pa_en high cycles 1–9.
  - tx_addr 0,1,2,3 on cycles 3–6.
  - rx_valid high cycles 10–14, rx_first at cycle 10.
  - busy falls after cycle 14.
- Same lengths with rx_mode=1: rx_valid high cycles 3–7; busy high cycles 1–9.
- T=0, L=2, G=2, R=3: pa_en and tx_valid never assert; rx_valid high cycles 1–3.
- trig repeated on cycles 0, 4 and 8 with a 14-cycle pulse: one pulse only, overrun=2. overrun_clr asserted together with a rejected trig leaves overrun=0.
- en dropped at cycle 5 of the L=2, T=4 case: all outputs 0 and tx_addr 0 at cycle 6; the next accepted trigger restarts at tx_addr 0.
